// File: rtl/instr_decode_cond_pkg.sv
// Shared decode constants: opcodes, condition codes, field positions and flag indices.
// Imported by the decoder, the condition evaluator and the control FSM.
package instr_decode_cond_pkg;

  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_SUB = 4'h1;
  localparam logic [3:0] OP_AND = 4'h2;
  localparam logic [3:0] OP_OR  = 4'h3;
  localparam logic [3:0] OP_XOR = 4'h4;
  localparam logic [3:0] OP_MOV = 4'h5;
  localparam logic [3:0] OP_LDI = 4'h6;
  localparam logic [3:0] OP_LD  = 4'h7;
  localparam logic [3:0] OP_ST  = 4'h8;
  localparam logic [3:0] OP_CMP = 4'h9;
  localparam logic [3:0] OP_J   = 4'hF;

  typedef enum logic [2:0] {
    COND_AL = 3'b000,
    COND_EQ = 3'b001,
    COND_NE = 3'b010,
    COND_LT = 3'b011,
    COND_GE = 3'b100,
    COND_CS = 3'b101,
    COND_CC = 3'b110,
    COND_NV = 3'b111
  } cond_e;

  // Bit positions within the 16-bit instruction word.
  localparam int OP_HI   = 15;
  localparam int OP_LO   = 12;
  localparam int LMC_BIT = 11;
  localparam int COND_HI = 10;
  localparam int COND_LO = 8;
  localparam int RD_HI   = 7;
  localparam int RD_LO   = 4;
  localparam int RS_HI   = 3;
  localparam int RS_LO   = 0;
  localparam int IMM_HI  = 7;
  localparam int IMM_LO  = 0;

  localparam int FZ = 3;
  localparam int FN = 2;
  localparam int FC = 1;
  localparam int FV = 0;

endpackage

// File: rtl/instr_decode_cond_if.sv
// Bus between the control FSM (master) and the decode/condition block (slave).
interface instr_decode_cond_if #(
  parameter int WORD = 16,
  parameter int CNTW = 16
);
  logic [WORD-1:0] MemData;
  logic            IW;
  logic            FU;
  logic            ALUZ;
  logic            ALUN;
  logic            ALUC;
  logic            ALUV;
  logic [3:0]      Op;
  logic            LMC;
  logic            Perform;
  logic [3:0]      Rd;
  logic [3:0]      Rs;
  logic [7:0]      Imm;
  logic [3:0]      Flags;
  logic [CNTW-1:0] RetCount;
  logic [CNTW-1:0] SkipCount;

  modport master (
    output MemData, IW, FU, ALUZ, ALUN, ALUC, ALUV,
    input  Op, LMC, Perform, Rd, Rs, Imm, Flags, RetCount, SkipCount
  );

  modport slave (
    input  MemData, IW, FU, ALUZ, ALUN, ALUC, ALUV,
    output Op, LMC, Perform, Rd, Rs, Imm, Flags, RetCount, SkipCount
  );
endinterface

// File: rtl/instr_decode_cond_cond_eval.sv
// Purely combinational condition evaluator: condition field plus {Z,N,C,V} in, perform out.
module cond_eval
  import instr_decode_cond_pkg::*;
(
  input  logic [2:0] cond,
  input  logic [3:0] flags,
  output logic       perform
);

  always_comb begin
    perform = 1'b0;
    case (cond_e'(cond))
      COND_AL: perform = 1'b1;
      COND_EQ: perform = flags[FZ];
      COND_NE: perform = ~flags[FZ];
      COND_LT: perform = flags[FN] ^ flags[FV];
      COND_GE: perform = ~(flags[FN] ^ flags[FV]);
      COND_CS: perform = flags[FC];
      COND_CC: perform = ~flags[FC];
      COND_NV: perform = 1'b0;
      default: perform = 1'b0;
    endcase
  end

endmodule

// File: rtl/instr_decode_cond.sv
// Instruction register with same-cycle bypass, condition flags, condition evaluation
// and retired/skipped instruction counters feeding the multicycle control FSM.
module instr_decode_cond
  import instr_decode_cond_pkg::*;
#(
  parameter int WORD = 16,
  parameter int CNTW = 16
) (
  input logic CLK,
  input logic RESET,
  instr_decode_cond_if.slave bus
);

  logic [WORD-1:0] ir;
  logic [WORD-1:0] word;
  logic [3:0]      flags_q;
  logic [CNTW-1:0] ret_q;
  logic [CNTW-1:0] skip_q;
  logic            perform;

  // The FSM branches in the decode cycle itself, so IW bypasses the register.
  assign word = bus.IW ? bus.MemData : ir;

  cond_eval u_cond_eval (
    .cond    (word[COND_HI:COND_LO]),
    .flags   (flags_q),
    .perform (perform)
  );

  always_ff @(posedge CLK) begin
    if (RESET) begin
      ir      <= '0;
      flags_q <= '0;
      ret_q   <= '0;
      skip_q  <= '0;
    end else begin
      if (bus.IW) begin
        ir <= bus.MemData;
        if (perform) ret_q  <= ret_q + CNTW'(1);
        else         skip_q <= skip_q + CNTW'(1);
      end
      if (bus.FU) flags_q <= {bus.ALUZ, bus.ALUN, bus.ALUC, bus.ALUV};
    end
  end

  assign bus.Op        = word[OP_HI:OP_LO];
  assign bus.LMC       = word[LMC_BIT];
  assign bus.Rd        = word[RD_HI:RD_LO];
  assign bus.Rs        = word[RS_HI:RS_LO];
  assign bus.Imm       = word[IMM_HI:IMM_LO];
  assign bus.Perform   = perform;
  assign bus.Flags     = flags_q;
  assign bus.RetCount  = ret_q;
  assign bus.SkipCount = skip_q;

endmodule

// File: tb/tb_instr_decode_cond.sv
// Directed self-checking bench for instr_decode_cond with hand-computed expectations.
module tb_instr_decode_cond;

  logic CLK;
  logic RESET;
  int   compared;
  int   mismatched;

  instr_decode_cond_if #(.WORD(16), .CNTW(16)) bus ();

  instr_decode_cond #(.WORD(16), .CNTW(16)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Inputs change 1 time unit after the rising edge, well away from it.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic applyStimulus(input logic [15:0] mem, input logic iw, input logic fu,
                               input logic [3:0] alu);
    bus.MemData = mem;
    bus.IW      = iw;
    bus.FU      = fu;
    {bus.ALUZ, bus.ALUN, bus.ALUC, bus.ALUV} = alu;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] observed,
                             input logic [15:0] expected);
    compared++;
    assert (observed === expected)
    else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    RESET      = 1'b1;
    applyStimulus(16'h0000, 1'b0, 1'b0, 4'b0000);
    tick();
    tick();
    RESET = 1'b0;
    #1;
    checkOutput("rst_op", 16'(bus.Op), 16'h0);
    checkOutput("rst_lmc", 16'(bus.LMC), 16'h0);
    checkOutput("rst_imm", 16'(bus.Imm), 16'h0);
    checkOutput("rst_perform", 16'(bus.Perform), 16'h1);
    checkOutput("rst_flags", 16'(bus.Flags), 16'h0);
    checkOutput("rst_ret", bus.RetCount, 16'h0);
    checkOutput("rst_skip", bus.SkipCount, 16'h0);

    // Bypass decode of 5A12 in the IW cycle, then held from IR.
    applyStimulus(16'h5A12, 1'b1, 1'b0, 4'b0000);
    checkOutput("byp_op", 16'(bus.Op), 16'h5);
    checkOutput("byp_lmc", 16'(bus.LMC), 16'h1);
    checkOutput("byp_rd", 16'(bus.Rd), 16'h1);
    checkOutput("byp_rs", 16'(bus.Rs), 16'h2);
    checkOutput("byp_imm", 16'(bus.Imm), 16'h12);
    checkOutput("byp_perform", 16'(bus.Perform), 16'h1);
    tick();
    applyStimulus(16'h0000, 1'b0, 1'b0, 4'b0000);
    checkOutput("hold_op", 16'(bus.Op), 16'h5);
    checkOutput("hold_rd", 16'(bus.Rd), 16'h1);
    checkOutput("hold_lmc", 16'(bus.LMC), 16'h1);
    checkOutput("hold_ret", bus.RetCount, 16'h1);
    checkOutput("hold_skip", bus.SkipCount, 16'h0);

    // Z=1 then J EQ performs, J NE skips.
    applyStimulus(16'h0000, 1'b0, 1'b1, 4'b1000);
    tick();
    applyStimulus(16'hF100, 1'b1, 1'b0, 4'b0000);
    checkOutput("z_flags", 16'(bus.Flags), 16'h8);
    checkOutput("j_op", 16'(bus.Op), 16'hF);
    checkOutput("eq_perform", 16'(bus.Perform), 16'h1);
    tick();
    applyStimulus(16'hF200, 1'b1, 1'b0, 4'b0000);
    checkOutput("ne_perform", 16'(bus.Perform), 16'h0);
    tick();
    applyStimulus(16'h0000, 1'b0, 1'b0, 4'b0000);
    checkOutput("ne_ir_perform", 16'(bus.Perform), 16'h0);
    checkOutput("ne_skip", bus.SkipCount, 16'h1);
    checkOutput("ne_ret", bus.RetCount, 16'h2);

    // Clear flags, then IW and FU on the same edge: Perform sees old flags.
    applyStimulus(16'h0000, 1'b0, 1'b1, 4'b0000);
    tick();
    applyStimulus(16'h0100, 1'b1, 1'b1, 4'b1000);
    checkOutput("same_flags_pre", 16'(bus.Flags), 16'h0);
    checkOutput("same_perform", 16'(bus.Perform), 16'h0);
    tick();
    applyStimulus(16'h0000, 1'b0, 1'b0, 4'b0000);
    checkOutput("same_flags_post", 16'(bus.Flags), 16'h8);
    checkOutput("same_ir_perform", 16'(bus.Perform), 16'h1);
    checkOutput("same_skip", bus.SkipCount, 16'h2);

    // N=1, V=0: LT true, GE false, NV false, AL true.
    applyStimulus(16'h0000, 1'b0, 1'b1, 4'b0100);
    tick();
    applyStimulus(16'h0300, 1'b1, 1'b0, 4'b0000);
    checkOutput("n_flags", 16'(bus.Flags), 16'h4);
    checkOutput("lt_perform", 16'(bus.Perform), 16'h1);
    tick();
    applyStimulus(16'h0400, 1'b1, 1'b0, 4'b0000);
    checkOutput("ge_perform", 16'(bus.Perform), 16'h0);
    tick();
    applyStimulus(16'h0700, 1'b1, 1'b0, 4'b0000);
    checkOutput("nv_perform", 16'(bus.Perform), 16'h0);
    tick();
    applyStimulus(16'h0000, 1'b1, 1'b0, 4'b0000);
    checkOutput("al_perform", 16'(bus.Perform), 16'h1);
    tick();

    // C=1: CS true, CC false.
    applyStimulus(16'h0000, 1'b0, 1'b1, 4'b0010);
    tick();
    applyStimulus(16'h0500, 1'b1, 1'b0, 4'b0000);
    checkOutput("c_flags", 16'(bus.Flags), 16'h2);
    checkOutput("cs_perform", 16'(bus.Perform), 16'h1);
    tick();
    applyStimulus(16'h0600, 1'b1, 1'b0, 4'b0000);
    checkOutput("cc_perform", 16'(bus.Perform), 16'h0);
    tick();
    applyStimulus(16'h0000, 1'b0, 1'b0, 4'b0000);
    checkOutput("mid_ret", bus.RetCount, 16'h5);
    checkOutput("mid_skip", bus.SkipCount, 16'h5);

    // Run RetCount up to FFFF, then wrap to 0000.
    applyStimulus(16'h0000, 1'b1, 1'b0, 4'b0000);
    for (int i = 0; i < 65530; i++) tick();
    applyStimulus(16'h0000, 1'b0, 1'b0, 4'b0000);
    checkOutput("ret_full", bus.RetCount, 16'hFFFF);
    checkOutput("skip_full", bus.SkipCount, 16'h5);
    applyStimulus(16'h0000, 1'b1, 1'b0, 4'b0000);
    tick();
    applyStimulus(16'h0000, 1'b0, 1'b0, 4'b0000);
    checkOutput("ret_wrap", bus.RetCount, 16'h0);
    applyStimulus(16'h0000, 1'b1, 1'b0, 4'b0000);
    tick();
    applyStimulus(16'h0000, 1'b0, 1'b0, 4'b0000);
    checkOutput("ret_after_wrap", bus.RetCount, 16'h1);

    // Reset overrides a simultaneous IW and FU.
    RESET = 1'b1;
    applyStimulus(16'h5A12, 1'b1, 1'b1, 4'b1111);
    tick();
    RESET = 1'b0;
    applyStimulus(16'h0000, 1'b0, 1'b0, 4'b0000);
    checkOutput("rst2_op", 16'(bus.Op), 16'h0);
    checkOutput("rst2_rd", 16'(bus.Rd), 16'h0);
    checkOutput("rst2_perform", 16'(bus.Perform), 16'h1);
    checkOutput("rst2_flags", 16'(bus.Flags), 16'h0);
    checkOutput("rst2_ret", bus.RetCount, 16'h0);
    checkOutput("rst2_skip", bus.SkipCount, 16'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/instr_decode_cond.md
Name: instr_decode_cond

Overview:
- Upstream neighbour of the multicycle control FSM.
- Captures the fetched instruction word and supplies Op, LMC and Perform to the FSM.
- Holds the architectural condition flags, updated by CMP, and evaluates the per-instruction condition field.
- Keeps retired and skipped instruction counters for debug and performance readout.

Parameters:
- WORD, 16, instruction and memory data width.
- CNTW, 16, width of the retired and skipped counters.

Ports:
- CLK  in  1  system clock; all state updates on the rising edge.
- RESET  in  1  synchronous, active-high reset.
- MemData  in  WORD  memory read data; holds the fetched instruction while IW=1.
- IW  in  1  instruction write; the control FSM asserts it in the decode state.
- FU  in  1  flag update; the control FSM asserts it in the calc state for CMP.
- ALUZ, ALUN, ALUC, ALUV  in  1 each  ALU result flags: zero, negative, carry, overflow.
- Op  out  4  opcode, field [15:12].
- LMC  out  1  load-memory-cycle bit, field [11].
- Perform  out  1  condition-satisfied indication.
- Rd  out  4  destination register, field [7:4].
- Rs  out  4  source register, field [3:0].
- Imm  out  8  immediate, field [7:0].
- Flags  out  4  registered flags {Z,N,C,V}.
- RetCount  out  CNTW  instructions decoded with Perform=1.
- SkipCount  out  CNTW  instructions decoded with Perform=0.

Behaviour:
- Instruction format:
  - [15:12] Op
  - [11] LMC
  - [10:8] Cond
  - [7:4] Rd
  - [3:0] Rs
  - [7:0] Imm
- Word source (bypass): when IW=1, all decoded outputs come combinationally from MemData. The FSM branches on Op/Perform in the same cycle IW is high. When IW=0, they come from IR.
- IR loads MemData on the rising edge when IW=1. Otherwise IR holds.
- Cond encoding, with Perform as the result:
  - 000: always, 1
  - 001: EQ, Z
  - 010: NE, ~Z
  - 011: LT, N^V
  - 100: GE, ~(N^V)
  - 101: CS, C
  - 110: CC, ~C
  - 111: never, 0
- Perform is evaluated against the registered Flags, never against the ALU inputs.
- Flags load {ALUZ,ALUN,ALUC,ALUV} on the rising edge when FU=1. Otherwise Flags hold.
- Simultaneous IW and FU: Perform for the incoming word uses the pre-edge Flags. Both registers update on the same edge.
- Counters:
  - On each edge with IW=1, RetCount increments if Perform=1, else SkipCount increments.
  - Both counters wrap modulo 2^CNTW; 16'hFFFF+1 becomes 16'h0000 with no saturation and no flag.
- Reset (RESET=1 at the edge) overrides IW and FU: IR=0, Flags=0, RetCount=0, SkipCount=0.
- Post-reset outputs with IW=0:
  - Op=0, LMC=0, Rd=0, Rs=0, Imm=0
  - Perform=1, since Cond=000
  - Flags=4'b0000
- Reset asserted mid-instruction discards the held word. The FSM restarts at fetch, so no recovery logic is required.
- Latency:
  - Decode outputs: 0 cycles from MemData under IW; stable from IR on the following cycles.
  - Flags: visible 1 cycle after FU.
  - Counters: visible 1 cycle after IW.
- No X propagation: all registers are defined after the first reset edge.

Decomposition:
- Shared package holds:
  - opcode constants (ADD..J, 4-bit), shared with the control FSM
  - Cond codes COND_AL..COND_NV (3-bit)
  - field position constants
  - flag index constants FZ=3, FN=2, FC=1, FV=0
- One natural sub-module: cond_eval. It is purely combinational: Cond[2:0] plus Flags[3:0] in, Perform out. It is reused by any future branch predictor.
- IR, flags and counters stay in the top module.

Test Plan:
- Reset then idle -> Op=0, Perform=1, Flags=0, RetCount=0, SkipCount=0.
- MemData=16'h5A12 with IW=1 -> same cycle: Op=5, LMC=1, Cond=010, Rd=1, Rs=2, Perform=1 (Z=0). Next cycle with IW=0, outputs hold; RetCount=1.
- FU=1 with ALUZ=1, others 0, then IW with MemData=16'hF100 (J, EQ) -> Perform=1. Then IW with 16'hF200 (NE) -> Perform=0; SkipCount=1.
- Same-edge IW=1 (MemData=16'h0100, EQ) and FU=1 (ALUZ=1) from Flags=0 -> Perform=0 for that word; Flags=4'b1000 next cycle.
- Flags N=1, V=0: Cond 011 -> 1, Cond 100 -> 0. Cond 111 with any flags -> 0. Cond 000 -> 1.
- Preload RetCount to 16'hFFFF via 65535 performed fetches, then one more -> RetCount=16'h0000. Assert RESET together with IW=1 -> IR, Flags and both counters are 0 next cycle.
